// File: rtl/mailbox_fifo_mbx.sv
// Multi-channel mailbox: one circular message FIFO per channel with a registered pop port,
// occupancy status, sticky overflow/underflow flags and per-channel doorbell interrupts.
module mailbox_fifo_mbx #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MSG_DEPTH    = 4,
    localparam int SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int CNT_W = $clog2(MSG_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          wr,
    input  logic [SEL_W-1:0]              wr_sel,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic                          wr_ready,
    input  logic                          rd,
    input  logic [SEL_W-1:0]              rd_sel,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          rvalid,
    input  logic [NUM_CHANNELS-1:0]       irq_en,
    output logic [NUM_CHANNELS-1:0]       irq,
    output logic [NUM_CHANNELS*CNT_W-1:0] ch_count,
    output logic [NUM_CHANNELS-1:0]       ovf,
    output logic [NUM_CHANNELS-1:0]       udf,
    input  logic [NUM_CHANNELS-1:0]       flag_clr
);

    localparam int PTR_W = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(MSG_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MSG_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [NUM_CHANNELS][MSG_DEPTH];

    logic [NUM_CHANNELS-1:0][PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NUM_CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0]            irq_q, irq_d, ovf_q, ovf_d, udf_q, udf_d;
    logic [NUM_CHANNELS-1:0]            wacc, wrej, racc, rrej;
    logic [DATA_WIDTH-1:0]              rdata_q, rdata_d;
    logic                               rvalid_q, rvalid_d;

    // Both strobes are judged against the pre-edge count, so a write into a full channel
    // is rejected even when the same cycle pops it, and a read of an empty one never bypasses.
    always_comb begin
        wr_ready = 1'b0;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wacc     = '0;
        wrej     = '0;
        racc     = '0;
        rrej     = '0;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        ch_count = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (wr_sel == SEL_W'(c)) begin
                wr_ready = (cnt_q[c] != CNT_FULL);
                wacc[c]  = wr & (cnt_q[c] != CNT_FULL);
                wrej[c]  = wr & (cnt_q[c] == CNT_FULL);
            end
            if (rd_sel == SEL_W'(c)) begin
                racc[c] = rd & (cnt_q[c] != '0);
                rrej[c] = rd & (cnt_q[c] == '0);
            end
            if (wacc[c]) begin
                wptr_d[c] = (wptr_q[c] == PTR_MAX) ? '0 : wptr_q[c] + 1'b1;
            end
            if (racc[c]) begin
                rptr_d[c] = (rptr_q[c] == PTR_MAX) ? '0 : rptr_q[c] + 1'b1;
                rdata_d   = mem_q[c][rptr_q[c]];
                rvalid_d  = 1'b1;
            end
            cnt_d[c] = cnt_q[c] + CNT_W'(wacc[c]) - CNT_W'(racc[c]);
            irq_d[c] = irq_en[c] & (cnt_d[c] != '0);
            ch_count[c*CNT_W +: CNT_W] = cnt_q[c];
        end
        // A flag being set wins over a simultaneous clear.
        ovf_d = wrej | (ovf_q & ~flag_clr);
        udf_d = rrej | (udf_q & ~flag_clr);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            irq_q    <= '0;
            ovf_q    <= '0;
            udf_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Message storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (wacc[c]) begin
                mem_q[c][wptr_q[c]] <= wdata;
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign irq    = irq_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule

// File: tb/tb_mailbox_fifo_mbx.sv
// Bench for mailbox_fifo_mbx: a 4x4 instance and a 4x3 instance (wrap and same-cycle cases),
// read data checked by per-instance scoreboard queues.
module tb_mailbox_fifo_mbx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    // Instance A: 4 channels, depth 4 (CNT_W = 3)
    logic        wr_a, rd_a, wr_ready_a, rvalid_a;
    logic [1:0]  wr_sel_a, rd_sel_a;
    logic [31:0] wdata_a, rdata_a;
    logic [3:0]  irq_en_a, irq_a, ovf_a, udf_a, flag_clr_a;
    logic [11:0] ch_count_a;

    // Instance B: 4 channels, depth 3 (CNT_W = 2)
    logic        wr_b, rd_b, wr_ready_b, rvalid_b;
    logic [1:0]  wr_sel_b, rd_sel_b;
    logic [31:0] wdata_b, rdata_b;
    logic [3:0]  irq_en_b, irq_b, ovf_b, udf_b, flag_clr_b;
    logic [7:0]  ch_count_b;

    mailbox_fifo_mbx #(.NUM_CHANNELS(4), .DATA_WIDTH(32), .MSG_DEPTH(4)) dut_a (
        .clk(clk), .resetn(resetn),
        .wr(wr_a), .wr_sel(wr_sel_a), .wdata(wdata_a), .wr_ready(wr_ready_a),
        .rd(rd_a), .rd_sel(rd_sel_a), .rdata(rdata_a), .rvalid(rvalid_a),
        .irq_en(irq_en_a), .irq(irq_a), .ch_count(ch_count_a),
        .ovf(ovf_a), .udf(udf_a), .flag_clr(flag_clr_a)
    );

    mailbox_fifo_mbx #(.NUM_CHANNELS(4), .DATA_WIDTH(32), .MSG_DEPTH(3)) dut_b (
        .clk(clk), .resetn(resetn),
        .wr(wr_b), .wr_sel(wr_sel_b), .wdata(wdata_b), .wr_ready(wr_ready_b),
        .rd(rd_b), .rd_sel(rd_sel_b), .rdata(rdata_b), .rvalid(rvalid_b),
        .irq_en(irq_en_b), .irq(irq_b), .ch_count(ch_count_b),
        .ovf(ovf_b), .udf(udf_b), .flag_clr(flag_clr_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] a_cnt(input int c);
        return ch_count_a[c*3 +: 3];
    endfunction

    function automatic logic [1:0] b_cnt(input int c);
        return ch_count_b[c*2 +: 2];
    endfunction

    // Monitors: every rvalid pops the oldest expected word of that instance.
    always @(negedge clk) begin
        if (rvalid_a) begin
            if (exp_a.size() == 0) chk("a_unexpected_rvalid", {32'h0, rdata_a}, 64'hDEAD);
            else chk("a_rdata", {32'h0, rdata_a}, {32'h0, exp_a.pop_front()});
        end
        if (rvalid_b) begin
            if (exp_b.size() == 0) chk("b_unexpected_rvalid", {32'h0, rdata_b}, 64'hDEAD);
            else chk("b_rdata", {32'h0, rdata_b}, {32'h0, exp_b.pop_front()});
        end
    end

    task automatic a_op(input logic w, input logic [1:0] ws, input logic [31:0] wd,
                        input logic r, input logic [1:0] rs);
        wr_a = w; wr_sel_a = ws; wdata_a = wd; rd_a = r; rd_sel_a = rs;
        @(posedge clk); #1;
        wr_a = 1'b0; rd_a = 1'b0; flag_clr_a = '0;
    endtask

    task automatic b_op(input logic w, input logic [1:0] ws, input logic [31:0] wd,
                        input logic r, input logic [1:0] rs);
        wr_b = w; wr_sel_b = ws; wdata_b = wd; rd_b = r; rd_sel_b = rs;
        @(posedge clk); #1;
        wr_b = 1'b0; rd_b = 1'b0; flag_clr_b = '0;
    endtask

    initial begin
        resetn = 1'b0;
        wr_a = 0; rd_a = 0; wr_sel_a = 0; rd_sel_a = 0; wdata_a = 0; irq_en_a = 0; flag_clr_a = 0;
        wr_b = 0; rd_b = 0; wr_sel_b = 0; rd_sel_b = 0; wdata_b = 0; irq_en_b = 0; flag_clr_b = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {52'h0, ch_count_a}, 64'h0);
        chk("rst_rvalid", {63'h0, rvalid_a}, 64'h0);
        chk("rst_rdata", {32'h0, rdata_a}, 64'h0);
        chk("rst_irq", {60'h0, irq_a}, 64'h0);
        chk("rst_flags", {56'h0, ovf_a, udf_a}, 64'h0);
        resetn = 1'b1;
        wr_sel_a = 2'd2; #1;
        chk("wr_ready_empty", {63'h0, wr_ready_a}, 64'h1);

        // Fill channel 2, then overflow it
        for (int i = 0; i < 4; i++) a_op(1'b1, 2'd2, 32'hA0 + i, 1'b0, 2'd0);
        chk("fill_count2", {61'h0, a_cnt(2)}, 64'd4);
        chk("wr_ready_full", {63'h0, wr_ready_a}, 64'h0);
        wr_sel_a = 2'd1; #1;
        chk("wr_ready_other", {63'h0, wr_ready_a}, 64'h1);
        a_op(1'b1, 2'd2, 32'hA4, 1'b0, 2'd0);
        chk("ovf_set", {60'h0, ovf_a}, 64'h4);
        chk("ovf_count2", {61'h0, a_cnt(2)}, 64'd4);

        // Drain in order, then underflow
        for (int i = 0; i < 4; i++) begin
            exp_a.push_back(32'hA0 + i);
            a_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);
        end
        chk("drain_count2", {61'h0, a_cnt(2)}, 64'd0);
        a_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);
        chk("udf_rvalid", {63'h0, rvalid_a}, 64'h0);
        chk("udf_rdata_hold", {32'h0, rdata_a}, 64'hA3);
        chk("udf_set", {60'h0, udf_a}, 64'h4);
        flag_clr_a = 4'b0100;
        a_op(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
        chk("clr_flags", {56'h0, ovf_a, udf_a}, 64'h0);

        // Set beats clear in the same cycle
        flag_clr_a = 4'b0001;
        a_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        chk("set_wins", {60'h0, udf_a}, 64'h1);
        flag_clr_a = 4'b0001;
        a_op(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
        chk("clr_after", {60'h0, udf_a}, 64'h0);

        // Doorbell
        irq_en_a = 4'b0101;
        a_op(1'b1, 2'd0, 32'h10, 1'b0, 2'd0);
        chk("irq_ch0_on", {60'h0, irq_a}, 64'h1);
        a_op(1'b1, 2'd1, 32'h11, 1'b0, 2'd0);
        chk("irq_ch1_masked", {60'h0, irq_a}, 64'h1);
        a_op(1'b1, 2'd0, 32'h12, 1'b0, 2'd0);
        exp_a.push_back(32'h10);
        a_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        chk("irq_ch0_still", {60'h0, irq_a}, 64'h1);
        exp_a.push_back(32'h12);
        a_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        chk("irq_ch0_off", {60'h0, irq_a}, 64'h0);
        exp_a.push_back(32'h11);
        a_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);

        // Instance B: wrap with depth 3, two words resident, 10 simultaneous push/pop
        a_op(1'b1, 2'd0, 32'hD0, 1'b0, 2'd0);
        b_op(1'b1, 2'd0, 32'hD0, 1'b0, 2'd0);
        b_op(1'b1, 2'd0, 32'hD1, 1'b0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            exp_b.push_back(32'hD0 + i);
            b_op(1'b1, 2'd0, 32'hD2 + i, 1'b1, 2'd0);
            chk("wrap_count", {62'h0, b_cnt(0)}, 64'd2);
        end
        exp_b.push_back(32'hDA);
        b_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        exp_b.push_back(32'hDB);
        b_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        chk("wrap_empty", {62'h0, b_cnt(0)}, 64'd0);

        // Same-cycle push/pop on full then empty channel 1
        for (int i = 0; i < 3; i++) b_op(1'b1, 2'd1, 32'hE0 + i, 1'b0, 2'd0);
        chk("b_full_ready", {63'h0, wr_ready_b}, 64'h0);
        exp_b.push_back(32'hE0);
        b_op(1'b1, 2'd1, 32'hE3, 1'b1, 2'd1);
        chk("full_simul_ovf", {60'h0, ovf_b}, 64'h2);
        chk("full_simul_cnt", {62'h0, b_cnt(1)}, 64'd2);
        exp_b.push_back(32'hE1);
        b_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
        exp_b.push_back(32'hE2);
        b_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
        b_op(1'b1, 2'd1, 32'hF0, 1'b1, 2'd1);
        chk("empty_simul_udf", {60'h0, udf_b}, 64'h2);
        chk("empty_simul_cnt", {62'h0, b_cnt(1)}, 64'd1);
        exp_b.push_back(32'hF0);
        b_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
        chk("empty_simul_after", {62'h0, b_cnt(1)}, 64'd0);

        // Reset with traffic queued (ch0 holds 0xD0 from above)
        for (int i = 0; i < 3; i++) a_op(1'b1, 2'd3, 32'h30 + i, 1'b0, 2'd0);
        a_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
        chk("pre_rst_count3", {61'h0, a_cnt(3)}, 64'd3);
        chk("pre_rst_irq", {60'h0, irq_a}, 64'h1);
        chk("pre_rst_udf", {60'h0, udf_a}, 64'h2);
        resetn = 1'b0;
        exp_a.push_back(32'hD0);
        a_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        resetn = 1'b1;
        chk("mid_rst_count", {52'h0, ch_count_a}, 64'h0);
        chk("mid_rst_rvalid", {63'h0, rvalid_a}, 64'h0);
        chk("mid_rst_irq", {60'h0, irq_a}, 64'h0);
        chk("mid_rst_flags", {56'h0, ovf_a, udf_a}, 64'h0);
        void'(exp_a.pop_back());
        a_op(1'b0, 2'd0, 32'h0, 1'b1, 2'd3);
        chk("post_rst_udf", {60'h0, udf_a}, 64'h8);
        chk("post_rst_rvalid", {63'h0, rvalid_a}, 64'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_drained", 64'(exp_a.size()), 64'd0);
        chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
